// File: rtl/data_memory.sv
// data_memory: word-addressed RAM with synchronous write, gated combinational read, and index-pattern reset
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  // Reset loads mem[i] = i so that independent copies start identical; reset outranks a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_WIDTH'(i);
    end else if (wr == 1'b1) begin
      mem_q[addr] <= wdata;
    end
  end
  // Zero-latency read, forced to zero when not enabled; the stored value is shown, never wdata.
  always_comb begin
    rdata = rd ? mem_q[addr] : '0;
  end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: table-driven directed check of data_memory plus a full reset-pattern sweep
module tb_data_memory;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  int tests = 0;
  int failed = 0;

  data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) dut (
    .clk(clk), .reset(reset), .addr(addr), .rd(rd), .wr(wr), .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wr;
    logic        rd;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  localparam int N = 20;
  vec_t v [N];

  task automatic check(input string name, input int idx, input logic [31:0] exp);
    tests++;
    if (rdata !== exp) begin
      failed++;
      $display("FAIL %s[%0d]: addr=%0d rdata=%h expected=%h", name, idx, addr, rdata, exp);
    end
  endtask

  initial begin
    // Each row is driven at a falling edge, checked 1 time unit later (before the next
    // rising edge commits any write or reset encoded in that same row).
    v[0]  = '{1'b0, 1'b0, 1'b1, 7'd0,   32'h0,        32'h0000_0000};
    v[1]  = '{1'b0, 1'b0, 1'b1, 7'd42,  32'h0,        32'h0000_002A};
    v[2]  = '{1'b0, 1'b0, 1'b1, 7'd127, 32'h0,        32'h0000_007F};
    v[3]  = '{1'b0, 1'b0, 1'b0, 7'd10,  32'h0,        32'h0000_0000};
    v[4]  = '{1'b0, 1'b0, 1'b1, 7'd10,  32'h0,        32'h0000_000A};
    v[5]  = '{1'b0, 1'b1, 1'b0, 7'd3,   32'hDEADBEEF, 32'h0000_0000};
    v[6]  = '{1'b0, 1'b0, 1'b1, 7'd3,   32'h0,        32'hDEADBEEF};
    v[7]  = '{1'b0, 1'b0, 1'b1, 7'd4,   32'h0,        32'h0000_0004};
    v[8]  = '{1'b0, 1'b1, 1'b1, 7'd20,  32'h12345678, 32'h0000_0014};
    v[9]  = '{1'b0, 1'b0, 1'b1, 7'd20,  32'h0,        32'h12345678};
    v[10] = '{1'b0, 1'b1, 1'b1, 7'd3,   32'hCAFEF00D, 32'hDEADBEEF};
    v[11] = '{1'b0, 1'b0, 1'b1, 7'd3,   32'h0,        32'hCAFEF00D};
    v[12] = '{1'b1, 1'b1, 1'b1, 7'd3,   32'hFFFFFFFF, 32'hCAFEF00D};
    v[13] = '{1'b0, 1'b0, 1'b1, 7'd3,   32'h0,        32'h0000_0003};
    v[14] = '{1'b0, 1'b0, 1'b1, 7'd20,  32'h0,        32'h0000_0014};
    v[15] = '{1'b0, 1'b1, 1'b1, 7'd127, 32'hA5A5A5A5, 32'h0000_007F};
    v[16] = '{1'b0, 1'b0, 1'b1, 7'd127, 32'h0,        32'hA5A5A5A5};
    v[17] = '{1'b0, 1'b0, 1'b1, 7'd0,   32'h0,        32'h0000_0000};
    v[18] = '{1'b0, 1'b0, 1'b1, 7'd50,  32'hFFFF_FFFF, 32'h0000_0032};
    v[19] = '{1'b0, 1'b0, 1'b1, 7'd50,  32'h0,        32'h0000_0032};
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      reset = v[i].rst;
      wr    = v[i].wr;
      rd    = v[i].rd;
      addr  = v[i].addr;
      wdata = v[i].wdata;
      #1 check("vec", i, v[i].exp);
    end
    // Dirty a few words, reset again, and confirm every word holds its own index.
    @(negedge clk);
    reset = 1'b0; wr = 1'b1; rd = 1'b0; addr = 7'd64; wdata = 32'h5555_AAAA;
    @(negedge clk);
    reset = 1'b1; wr = 1'b0;
    @(negedge clk);
    reset = 1'b0; rd = 1'b1;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      addr = 7'(i);
      #1 check("sweep", i, 32'(i));
    end
    // Zero-latency address and enable changes within a single cycle, no edge in between.
    @(negedge clk);
    addr = 7'd99;
    #1 check("comb", 0, 32'h63);
    addr = 7'd1;
    #1 check("comb", 1, 32'h1);
    rd = 1'b0;
    #1 check("comb", 2, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-organised data memory for the single-cycle/pipelined MIPS datapath and its reference checker.
- Serves LW reads and SW writes.
- 2^ADDR_WIDTH words of DATA_WIDTH bits.
- Synchronous write, combinational (asynchronous) read gated by a read enable.
- Synchronous reset loads a deterministic pattern so the processor's copy and the checker's copy hold identical contents.

Parameters:
- DATA_WIDTH, 32, width of each word and of rdata/wdata.
- ADDR_WIDTH, 7, address width; depth = 2^ADDR_WIDTH = 128 words.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- addr  input  ADDR_WIDTH  word index (not byte address); all bits used, no alignment dropping.
- rd  input  1  read enable.
- wr  input  1  write enable.
- wdata  input  DATA_WIDTH  write data.
- rdata  output  DATA_WIDTH  read data.

Behaviour:
- Storage: array mem[0..2^ADDR_WIDTH-1] of DATA_WIDTH bits.
- Reset:
  - reset sampled high at a rising edge sets mem[i] = i for every i, zero-extended to DATA_WIDTH (e.g. mem[5] = 32'h0000_0005).
  - Reset has priority over wr; a write in a reset cycle is discarded.
  - Reset asserted mid-operation wipes previously written data at that edge.
- Write:
  - At a rising edge with reset=0 and wr=1, mem[addr] <= wdata.
  - Full-word write, no byte enables.
  - wr=0 leaves memory unchanged.
- Read:
  - Purely combinational.
  - rd=1: rdata = mem[addr]. rd=0: rdata = 0.
  - Zero-cycle latency from addr/rd change to rdata.
  - rd has no effect on state.
- Read-during-write, same address:
  - Before the edge, rdata shows the old contents.
  - After the edge, it shows wdata (no write-through bypass).
- rd and wr both high: legal; the write occurs at the edge, the read follows the rule above.
- Address range: every ADDR_WIDTH-bit value is valid. Index 127 is the last word; no wrap logic is needed because addr cannot exceed depth.
- Unknown inputs: X on wr during a non-reset edge is not permitted. The implementation must not write when wr is not 1'b1.
- Before the first reset, memory contents are undefined.
- No outputs other than rdata. rdata's value under reset follows the read rule, using post-reset contents after the reset edge.

Test Plan:
- Reset then read: reset=1 for one edge, then reset=0, rd=1, addr=7'd0/7'd42/7'd127 -> rdata = 32'h0, 32'h2A, 32'h7F immediately.
- Read enable gating: after reset, addr=7'd10, rd=0 -> rdata = 32'h0; raise rd -> rdata = 32'h0000000A in the same cycle.
- Write/readback: wr=1, addr=7'd3, wdata=32'hDEADBEEF for one edge, then wr=0, rd=1, addr=3 -> rdata = 32'hDEADBEEF; addr=4 -> rdata = 32'h4 (neighbour untouched).
- Read-during-write: rd=1, wr=1, addr=7'd20, wdata=32'h12345678 -> rdata = 32'h14 before the edge, 32'h12345678 after it.
- Reset beats write: reset=1, wr=1, addr=7'd3, wdata=32'hFFFFFFFF at the same edge, after earlier writing 32'hCAFEF00D to addr 3 -> afterwards rdata at addr 3 = 32'h3.
- Boundary write: wr=1, addr=7'd127, wdata=32'hA5A5A5A5 -> addr 127 reads 32'hA5A5A5A5, addr 0 still reads 32'h0.
